// File: rtl/aes_pkg.sv
// Shared AES datapath types and sizes, used by the block packer and aes_ctr.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [4:0]             aes_len_t;

    // Block with every byte lane set to the same value (empty fill register).
    function automatic aes_block_t aes_fill_block(input logic [7:0] b);
        return {AES_BLOCK_BYTES{b}};
    endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit AES blocks, byte 0 in bits [127:120].
// Two stages: a fill register collecting bytes, and a registered output
// slice holding one block for the consumer. A short final block is padded
// with PAD_BYTE and carries its byte count and end-of-message flag.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [7:0]   s_data_i,
    input  logic         s_valid_i,
    input  logic         s_last_i,
    output logic         s_ready_o,
    output logic [127:0] blk_o,
    output logic [4:0]   blk_len_o,
    output logic         blk_last_o,
    output logic         blk_valid_o,
    input  logic         blk_ready_i
);

    aes_block_t fill_reg_q, fill_reg_d;
    aes_len_t   fill_cnt_q, fill_cnt_d;
    logic       fill_last_q, fill_last_d;
    logic       fill_done_q, fill_done_d;

    aes_block_t out_reg_q, out_reg_d;
    aes_len_t   out_len_q, out_len_d;
    logic       out_last_q, out_last_d;
    logic       out_valid_q, out_valid_d;

    logic       accept;
    logic       xfer;

    // Input handshake and fill-to-output transfer qualifiers.
    always_comb begin
        accept = s_valid_i && !fill_done_q;
        xfer   = fill_done_q && (!out_valid_q || blk_ready_i);
    end

    // Next-state for both stages; clear overrides everything else.
    always_comb begin
        fill_reg_d  = fill_reg_q;
        fill_cnt_d  = fill_cnt_q;
        fill_last_d = fill_last_q;
        fill_done_d = fill_done_q;
        out_reg_d   = out_reg_q;
        out_len_d   = out_len_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (clr_i) begin
            fill_reg_d  = aes_fill_block(PAD_BYTE);
            fill_cnt_d  = '0;
            fill_last_d = 1'b0;
            fill_done_d = 1'b0;
            out_reg_d   = '0;
            out_len_d   = '0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            // accept and xfer are exclusive: one needs fill_done low, the other high.
            if (xfer) begin
                out_reg_d   = fill_reg_q;
                out_len_d   = fill_cnt_q;
                out_last_d  = fill_last_q;
                out_valid_d = 1'b1;
                fill_reg_d  = aes_fill_block(PAD_BYTE);
                fill_cnt_d  = '0;
                fill_last_d = 1'b0;
                fill_done_d = 1'b0;
            end else if (out_valid_q && blk_ready_i) begin
                out_valid_d = 1'b0;
            end

            if (accept) begin
                for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
                    if (fill_cnt_q == 5'(k)) begin
                        fill_reg_d[AES_BLOCK_W-1-8*k -: 8] = s_data_i;
                    end
                end
                fill_cnt_d = fill_cnt_q + 5'd1;
                if (fill_cnt_q == 5'(AES_BLOCK_BYTES - 1) || s_last_i) begin
                    fill_done_d = 1'b1;
                    fill_last_d = s_last_i;
                end
            end
        end
    end

    // State registers for the fill and output stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg_q  <= aes_fill_block(PAD_BYTE);
            fill_cnt_q  <= '0;
            fill_last_q <= 1'b0;
            fill_done_q <= 1'b0;
            out_reg_q   <= '0;
            out_len_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fill_reg_q  <= fill_reg_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_last_q <= fill_last_d;
            fill_done_q <= fill_done_d;
            out_reg_q   <= out_reg_d;
            out_len_q   <= out_len_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        s_ready_o   = !fill_done_q;
        blk_o       = out_reg_q;
        blk_len_o   = out_len_q;
        blk_last_o  = out_last_q;
        blk_valid_o = out_valid_q;
    end

endmodule
